// File: rtl/muldiv_pkg.sv
// Shared types for the MIPS multiply/divide unit: operation codes, FSM states
// and the two's-complement magnitude helper used during operand preparation.
package muldiv_pkg;

  localparam int MD_WIDTH = 32;

  typedef enum logic [1:0] {
    MULTU = 2'd0,
    MULT  = 2'd1,
    DIVU  = 2'd2,
    DIV   = 2'd3
  } op_e;

  // State literals carry an ST_ prefix so they cannot clash with the op_e names.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_e;

  // Magnitude of a two's-complement value; the most negative value maps to itself,
  // which is still correct when the result is read as unsigned.
  function automatic logic [MD_WIDTH-1:0] abs_w(input logic [MD_WIDTH-1:0] v);
    return v[MD_WIDTH-1] ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One combinational restoring-division step: subtract the divisor from the
// shifted partial remainder and keep the difference only when it did not borrow.
module muldiv_div_step #(
  parameter int W = 32
) (
  input  logic [W:0]   i_partial,
  input  logic [W-1:0] i_divisor,
  output logic [W-1:0] o_rem,
  output logic         o_qbit
);

  logic [W:0] w_diff;

  assign w_diff = i_partial - {1'b0, i_divisor};
  // The top bit of the W+1-bit difference is the borrow.
  assign o_qbit = ~w_diff[W];
  assign o_rem  = o_qbit ? w_diff[W-1:0] : i_partial[W-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine with MIPS HI/LO registers.
// Define MULDIV_FAST_MUL_EN to replace the shift-add multiplier with a single-cycle W x W multiply.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = MD_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  op_e                   op,
  input  logic [DATA_WIDTH-1:0] srcA,
  input  logic [DATA_WIDTH-1:0] srcB,
  input  logic                  hiWrite,
  input  logic                  loWrite,
  input  logic [DATA_WIDTH-1:0] wrData,
  output logic                  busy,
  output logic                  done,
  output logic                  divByZero,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(W);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [W-1:0]     r_acc_hi;   // MUL: product high half; DIV: partial remainder
  logic [W-1:0]     r_acc_lo;   // MUL: product low half / multiplier; DIV: dividend -> quotient
  logic [W-1:0]     r_opnd;     // MUL: multiplicand magnitude; DIV: divisor magnitude
  logic             r_is_div;
  logic             r_neg_res;
  logic             r_neg_rem;
  logic             r_dbz;
  logic [W-1:0]     r_hi;
  logic [W-1:0]     r_lo;
  logic             r_done;
  logic             r_dbz_out;

  logic             w_is_signed;
  logic             w_start_div;
  logic [W-1:0]     w_a_mag;
  logic [W-1:0]     w_b_mag;
  logic [W-1:0]     w_step_rem;
  logic             w_step_qbit;
  logic [2*W-1:0]   w_prod;
  logic [2*W-1:0]   w_prod_fix;
  logic [W-1:0]     w_quot_fix;
  logic [W-1:0]     w_rem_fix;

  assign w_is_signed = (op == MULT) || (op == DIV);
  assign w_start_div = (op == DIVU) || (op == DIV);
  assign w_a_mag     = w_is_signed ? abs_w(srcA) : srcA;
  assign w_b_mag     = w_is_signed ? abs_w(srcB) : srcB;

  muldiv_div_step #(.W(W)) u_div_step (
    .i_partial (({r_acc_hi, r_acc_lo[W-1]})),
    .i_divisor (r_opnd),
    .o_rem     (w_step_rem),
    .o_qbit    (w_step_qbit)
  );

`ifdef MULDIV_FAST_MUL_EN
  logic [2*W-1:0] w_fast_prod;
  assign w_fast_prod = {{W{1'b0}}, r_opnd} * {{W{1'b0}}, r_acc_lo};
`else
  logic [W:0] w_mul_sum;
  assign w_mul_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd} : {(W+1){1'b0}});
`endif

  assign w_prod     = {r_acc_hi, r_acc_lo};
  assign w_prod_fix = r_neg_res ? -w_prod : w_prod;
  // With a zero divisor every step shifts a dividend bit into the remainder,
  // so after W steps it holds |srcA| and the dividend-sign fixup restores srcA.
  assign w_quot_fix = r_dbz ? {W{1'b1}} : (r_neg_res ? -r_acc_lo : r_acc_lo);
  assign w_rem_fix  = r_neg_rem ? -r_acc_hi : r_acc_hi;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_acc_hi  <= '0;
      r_acc_lo  <= '0;
      r_opnd    <= '0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_dbz     <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
      r_dbz_out <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading pre-edge values,
      // so the order of statements below does not change the hardware.
      r_done    <= 1'b0;
      r_dbz_out <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (hiWrite) r_hi <= wrData;
          if (loWrite) r_lo <= wrData;
          if (start) begin
            r_cnt     <= '0;
            r_acc_hi  <= '0;
            r_acc_lo  <= w_start_div ? w_a_mag : w_b_mag;
            r_opnd    <= w_start_div ? w_b_mag : w_a_mag;
            r_is_div  <= w_start_div;
            r_neg_res <= w_is_signed & (srcA[W-1] ^ srcB[W-1]);
            r_neg_rem <= w_is_signed & srcA[W-1];
            r_dbz     <= w_start_div && (srcB == '0);
            r_state   <= w_start_div ? ST_DIV : ST_MUL;
          end
        end
        ST_MUL: begin
`ifdef MULDIV_FAST_MUL_EN
          {r_acc_hi, r_acc_lo} <= w_fast_prod;
          r_state              <= ST_FIX;
`else
          r_acc_hi <= w_mul_sum[W:1];
          r_acc_lo <= {w_mul_sum[0], r_acc_lo[W-1:1]};
          r_cnt    <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(W-1)) r_state <= ST_FIX;
`endif
        end
        ST_DIV: begin
          r_acc_hi <= w_step_rem;
          r_acc_lo <= {r_acc_lo[W-2:0], w_step_qbit};
          r_cnt    <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(W-1)) r_state <= ST_FIX;
        end
        ST_FIX: begin
          if (r_is_div) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quot_fix;
          end else begin
            {r_hi, r_lo} <= w_prod_fix;
          end
          r_done    <= 1'b1;
          r_dbz_out <= r_dbz;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;
  assign divByZero = r_dbz_out;
  assign hi        = r_hi;
  assign lo        = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: results, latency, divide-by-zero,
// busy-time write/start suppression and asynchronous reset mid-operation.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W       = 32;
  localparam int DIV_LAT = W + 2;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 3;
`else
  localparam int MUL_LAT = W + 2;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  op_e          op = MULTU;
  logic [W-1:0] srcA = '0;
  logic [W-1:0] srcB = '0;
  logic         hiWrite = 1'b0;
  logic         loWrite = 1'b0;
  logic [W-1:0] wrData = '0;
  logic         busy;
  logic         done;
  logic         divByZero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_checks = 0;
  int n_errors = 0;

  muldiv_unit #(.DATA_WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .srcA      (srcA),
    .srcB      (srcB),
    .hiWrite   (hiWrite),
    .loWrite   (loWrite),
    .wrData    (wrData),
    .busy      (busy),
    .done      (done),
    .divByZero (divByZero),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Launch one operation and wait (bounded) for done. lat counts edges from the
  // sampling edge through the FIX edge; 0 means done never arrived.
  // inj > 0 drives a stray start at that cycle and an MTHI three cycles later.
  task automatic run_op(input op_e o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int inj, input logic mthi,
                        output int lat, output logic [W-1:0] h, output logic [W-1:0] l,
                        output logic dz, output logic b_first, output logic [W-1:0] hi_first,
                        output logic b_done);
    lat = 0; h = '0; l = '0; dz = 1'b0; b_first = 1'b0; hi_first = '0; b_done = 1'b1;
    @(negedge clk);
    op = o; srcA = a; srcB = b; start = 1'b1; hiWrite = mthi; wrData = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0; hiWrite = 1'b0; srcA = '0; srcB = '0;
    b_first  = busy;
    hi_first = hi;
    for (int n = 1; n <= 100; n++) begin
      if (done) begin
        lat = n; h = hi; l = lo; dz = divByZero; b_done = busy;
        break;
      end
      start = 1'b0; hiWrite = 1'b0;
      if (inj > 0 && n == inj) begin
        start = 1'b1; op = MULTU; srcA = 32'd1; srcB = 32'd1;
      end
      if (inj > 0 && n == inj + 3) begin
        hiWrite = 1'b1; wrData = 32'hAABB_CCDD;
      end
      @(negedge clk);
    end
    start = 1'b0; hiWrite = 1'b0;
  endtask

  task automatic op_test(input string tag, input op_e o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                         input logic [W-1:0] exp_lo, input logic exp_dz, input int exp_lat);
    int lat; logic [W-1:0] h, l, hf; logic dz, bf, bd;
    run_op(o, a, b, 0, 1'b0, lat, h, l, dz, bf, hf, bd);
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " hi"}, 64'(h), 64'(exp_hi));
    check({tag, " lo"}, 64'(l), 64'(exp_lo));
    check({tag, " divByZero"}, 64'(dz), 64'(exp_dz));
    check({tag, " busy after start"}, 64'(bf), 64'd1);
    check({tag, " busy with done"}, 64'(bd), 64'd0);
  endtask

  initial begin
    int lat; logic [W-1:0] h, l, hf; logic dz, bf, bd;
    int seen;

    repeat (2) @(negedge clk);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset divByZero", 64'(divByZero), 64'd0);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    reset = 1'b0;

    op_test("multu ffffffff*2", MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, MUL_LAT);
    op_test("mult -3*5", MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, MUL_LAT);

    // MTLO in the cycle after done overwrites the product.
    @(negedge clk);
    loWrite = 1'b1; wrData = 32'h0000_55AA;
    @(negedge clk);
    loWrite = 1'b0;
    check("mtlo after done", 64'(lo), 64'h0000_55AA);

    op_test("mult minneg^2", MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, MUL_LAT);
    op_test("mult -1*-1", MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, MUL_LAT);
    op_test("multu max*max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, MUL_LAT);

    op_test("div -7/2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, DIV_LAT);
    op_test("div 7/-2", DIV, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, DIV_LAT);
    op_test("divu 100/7", DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, DIV_LAT);
    op_test("divu 5/7", DIVU, 32'd5, 32'd7, 32'd5, 32'd0, 1'b0, DIV_LAT);
    op_test("div minneg/-1", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, DIV_LAT);
    op_test("divu 100/0", DIVU, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1, DIV_LAT);
    op_test("div -5/0", DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, DIV_LAT);

    // Stray start at cycle 5 and MTHI at cycle 8 while busy: both ignored.
    run_op(DIVU, 32'd1000, 32'd10, 5, 1'b0, lat, h, l, dz, bf, hf, bd);
    check("busy ignore latency", 64'(lat), 64'(DIV_LAT));
    check("busy ignore hi", 64'(h), 64'd0);
    check("busy ignore lo", 64'(l), 64'd100);
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (busy || done) seen++;
    end
    check("no second op", 64'(seen), 64'd0);

    // MTHI in the same cycle as start lands, then the result overwrites it.
    run_op(DIVU, 32'd9, 32'd3, 0, 1'b1, lat, h, l, dz, bf, hf, bd);
    check("mthi with start hi", 64'(hf), 64'hDEAD_BEEF);
    check("mthi with start busy", 64'(bf), 64'd1);
    check("mthi with start result hi", 64'(h), 64'd0);
    check("mthi with start result lo", 64'(l), 64'd3);

    op_test("preload multu", MULTU, 32'h1234_5678, 32'h0000_0100, 32'h0000_0012, 32'h3456_7800, 1'b0, MUL_LAT);

    // Reset at cycle 10 of a DIV.
    @(negedge clk);
    op = DIV; srcA = 32'd1000; srcB = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre-reset busy", 64'(busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("mid-op reset busy", 64'(busy), 64'd0);
    check("mid-op reset hi", 64'(hi), 64'd0);
    check("mid-op reset lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy || done) seen++;
    end
    check("aborted op stays idle", 64'(seen), 64'd0);
    loWrite = 1'b1; wrData = 32'h1234_5678;
    @(negedge clk);
    loWrite = 1'b0;
    check("mtlo after reset lo", 64'(lo), 64'h1234_5678);
    check("mtlo after reset hi", 64'(hi), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
